// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, drives the instruction-memory port and holds the
// IF/ID pipeline register. Branch redirects and IF/ID flushes arrive from the ID stage.
// Build option: define BRANCH_DELAY_SLOT_EN to let the sequential instruction after a taken
// branch enter ID as a delay slot; is_rst_IF_ID is then ignored.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_IF,
  input  logic              is_branch,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              is_rst_IF_ID,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_plus4_ID,
  output logic [DATA_W-1:0] inst_ID,
  output logic              valid_ID
);

  // StSlot is only entered when delay slots are enabled: the in-flight sequential fetch is kept.
  typedef enum logic [1:0] {StIdle, StFetch, StDiscard, StSlot} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              rsp;
  logic              keep;
  logic              flush;
  logic              unused_in;

  assign redirect = is_branch & ~stall_IF;
  assign target   = {branch_address[ADDR_W-1:2], 2'b00};
  assign rsp      = imem_req & imem_ready;

`ifdef BRANCH_DELAY_SLOT_EN
  // Any response that is not being discarded is kept, including the slot after a branch.
  assign flush     = 1'b0;
  assign keep      = rsp & ((state_q == StFetch) | (state_q == StSlot));
  assign unused_in = ^{branch_address[1:0], is_rst_IF_ID};
`else
  // A response arriving in the redirect cycle belongs to the wrong path and is dropped.
  assign flush     = is_rst_IF_ID;
  assign keep      = rsp & (state_q == StFetch) & ~redirect;
  assign unused_in = ^branch_address[1:0];
`endif

  // Memory port: request while fetching with an empty hold buffer, or while draining an
  // outstanding transaction whose address must stay stable.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      StFetch:           imem_req = ~hold_valid_q;
      StDiscard, StSlot: begin
        imem_req  = 1'b1;
        imem_addr = pend_addr_q;
      end
      default: ;
    endcase
  end

  // Next-state for the fetch FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    hold_valid_d = hold_valid_q;
    hold_pc4_d   = hold_pc4_q;
    hold_inst_d  = hold_inst_q;
    id_pc4_d     = id_pc4_q;
    id_inst_d    = id_inst_q;
    id_valid_d   = id_valid_q;

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (redirect && imem_req && !imem_ready) begin
          pend_addr_d = pc_q;
`ifdef BRANCH_DELAY_SLOT_EN
          state_d     = StSlot;
`else
          state_d     = StDiscard;
`endif
        end
      end
      StDiscard, StSlot: if (imem_ready) state_d = StFetch;
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      pc_d = target;
    end else if (keep && state_q == StFetch) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    if (!stall_IF) begin
      hold_valid_d = 1'b0;
      if (flush) begin
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end else if (hold_valid_q) begin
        id_pc4_d   = hold_pc4_q;
        id_inst_d  = hold_inst_q;
        id_valid_d = 1'b1;
      end else if (keep) begin
        id_pc4_d   = imem_addr + ADDR_W'(4);
        id_inst_d  = imem_rdata;
        id_valid_d = 1'b1;
      end else begin
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
    end else if (keep) begin
      // ID is frozen: park the word so the request can be withdrawn.
      hold_valid_d = 1'b1;
      hold_pc4_d   = imem_addr + ADDR_W'(4);
      hold_inst_d  = imem_rdata;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pend_addr_q  <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc4_q   <= '0;
      hold_inst_q  <= NOP_INST;
      id_pc4_q     <= '0;
      id_inst_q    <= NOP_INST;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_inst_q  <= hold_inst_d;
      id_pc4_q     <= id_pc4_d;
      id_inst_q    <= id_inst_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign pc_plus4_ID = id_pc4_q;
  assign inst_ID     = id_inst_q;
  assign valid_ID    = id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed steps followed by random stimulus, all
// compared against a transaction-level model of the fetch path.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int MNone = 0;
  localparam int MDrop = 1;
  localparam int MSlot = 2;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] w;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IF, is_branch, is_rst_IF_ID, imem_ready;
  logic [31:0] branch_address, imem_rdata;
  logic        imem_req, valid_ID;
  logic [31:0] imem_addr, pc_plus4_ID, inst_ID;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc4, w_inst, w_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_started;
  logic [31:0] m_pc, m_pend;
  int          m_mode;
  item_t       m_hold[$];
  logic [31:0] m_id_pc4, m_id_inst;
  logic        m_id_v;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign w_rdata = word(w_addr);

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .is_branch(is_branch),
    .branch_address(branch_address), .is_rst_IF_ID(is_rst_IF_ID),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_plus4_ID(pc_plus4_ID), .inst_ID(inst_ID),
    .valid_ID(valid_ID)
  );

  // Zero-wait instance starting at the top of the address space.
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall_IF(1'b0), .is_branch(1'b0),
    .branch_address(32'h0), .is_rst_IF_ID(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rdata(w_rdata), .pc_plus4_ID(w_pc4), .inst_ID(w_inst),
    .valid_ID(w_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return (m_mode != MNone) ? m_pend : m_pc;
  endfunction

  function automatic logic exp_req();
    return m_started && (m_mode != MNone || m_hold.size() == 0);
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_pc      = 32'h0;
    m_pend    = 32'h0;
    m_mode    = MNone;
    m_hold.delete();
    m_id_pc4  = 32'h0;
    m_id_inst = NOP;
    m_id_v    = 1'b0;
  endtask

  task automatic compare();
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    check("imem_addr", imem_addr, exp_addr());
    check("inst_ID", inst_ID, m_id_inst);
    check("pc_plus4_ID", pc_plus4_ID, m_id_pc4);
    check("valid_ID", {31'b0, valid_ID}, {31'b0, m_id_v});
  endtask

  // One clock cycle: drive inputs at the negedge, advance the model, compare at next negedge.
  task automatic step(input logic s, input logic b, input logic [31:0] ba, input logic f,
                      input logic r);
    logic [31:0] ea, w;
    logic        er, redir, got, kept, fl, hv;
    int          mode0;
    item_t       it;
    ea = exp_addr();
    er = exp_req();
    w  = word(ea);
    stall_IF = s; is_branch = b; branch_address = ba; is_rst_IF_ID = f;
    imem_ready = r; imem_rdata = w;
    mode0 = m_mode;
    redir = b && !s;
    got   = er && r;
`ifdef BRANCH_DELAY_SLOT_EN
    fl   = 1'b0;
    kept = got && (m_mode != MDrop);
`else
    fl   = f;
    kept = got && ((m_mode == MSlot) || (m_mode == MNone && !redir));
`endif
    it.pc4 = ea + 32'd4;
    it.w   = w;
    hv = (m_hold.size() != 0);
    if (!s) begin
      if (fl) begin
        m_id_inst = NOP; m_id_v = 1'b0;
      end else if (hv) begin
        m_id_pc4 = m_hold[0].pc4; m_id_inst = m_hold[0].w; m_id_v = 1'b1;
      end else if (kept) begin
        m_id_pc4 = it.pc4; m_id_inst = it.w; m_id_v = 1'b1;
      end else begin
        m_id_inst = NOP; m_id_v = 1'b0;
      end
      if (hv) m_hold.delete();
    end else if (kept) begin
      m_hold.push_back(it);
    end
    if (redir) m_hold.delete();
    if (!m_started) m_started = 1;
    else if (m_mode == MNone) begin
      if (redir && er && !r) begin
`ifdef BRANCH_DELAY_SLOT_EN
        m_mode = MSlot;
`else
        m_mode = MDrop;
`endif
        m_pend = m_pc;
      end
    end else if (r) m_mode = MNone;
    if (redir) m_pc = {ba[31:2], 2'b00};
    else if (kept && mode0 == MNone) m_pc = m_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic s, b, f, r;
    rst = 1'b0;
    stall_IF = 0; is_branch = 0; is_rst_IF_ID = 0; imem_ready = 0;
    branch_address = 0; imem_rdata = 0;
    model_reset();
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", inst_ID, NOP);
    check("rst_pc4", pc_plus4_ID, 32'h0);
    check("rst_valid", {31'b0, valid_ID}, 32'h0);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    rst = 1'b1;

    // Sequential zero-wait fetch
    step(0, 0, 0, 0, 1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_req", {31'b0, w_req}, 32'h1);
    step(0, 0, 0, 0, 1);
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_inst", w_inst, word(32'hFFFF_FFFC));
    step(0, 0, 0, 0, 1);
    check("seq_addr", imem_addr, 32'h8);
    check("seq_inst", inst_ID, word(32'h4));
    step(0, 0, 0, 0, 1);

`ifdef BRANCH_DELAY_SLOT_EN
    // Branch at 0x08 now in ID; 0x0C returns in the redirect cycle and is the delay slot.
    check("ds_branch", inst_ID, word(32'h8));
    step(0, 1, 32'h80, 0, 1);
    check("ds_slot", inst_ID, word(32'hC));
    check("ds_slot_v", {31'b0, valid_ID}, 32'h1);
    step(0, 0, 0, 0, 1);
    check("ds_target", inst_ID, word(32'h80));
    check("ds_target_pc4", pc_plus4_ID, 32'h84);
`else
    step(0, 0, 0, 0, 1);
    // Fetch at 0x10 stalled by memory; redirect+flush to 0x40 in the first wait cycle.
    check("pre_br_addr", imem_addr, 32'h10);
    step(0, 1, 32'h40, 1, 0);
    check("disc_addr", imem_addr, 32'h10);
    check("disc_valid", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("br_target", imem_addr, 32'h40);
    check("br_valid", {31'b0, valid_ID}, 32'h0);
    // Redirect with same-cycle response to 0x1C, then stall while 0x20 returns.
    step(0, 1, 32'h1C, 1, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("stall_inst", inst_ID, word(32'h1C));
    check("stall_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 0, 0);
    check("hold_inst", inst_ID, word(32'h20));
    check("hold_pc4", pc_plus4_ID, 32'h24);
    check("hold_req", {31'b0, imem_req}, 32'h1);
    // Unaligned branch target is word-aligned.
    step(0, 1, 32'h0000_0103, 1, 0);
    step(0, 0, 0, 0, 1);
    check("align_addr", imem_addr, 32'h100);
`endif

    // Random phase
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(3) == 0);
      b = ($urandom_range(5) == 0);
      r = ($urandom_range(2) != 0);
`ifdef BRANCH_DELAY_SLOT_EN
      f = ($urandom_range(3) == 0);
`else
      f = b | ($urandom_range(7) == 0);
`endif
      step(s, b, $urandom, f, r);
    end

    // Reset in the middle of a fetch drops the request immediately.
    step(0, 0, 0, 0, 0);
    check("pre_rst_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b0;
    #1;
    check("async_req", {31'b0, imem_req}, 32'h0);
    check("async_addr", imem_addr, 32'h0);
    check("async_valid", {31'b0, valid_ID}, 32'h0);
    check("async_inst", inst_ID, NOP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
